// File: rtl/wide_add_pkg.sv
// Shared definitions for the slice-serial wide adder.
// Provides the FSM state encoding, the default slice width and a helper
// that sizes the slice index register.
package wide_add_pkg;

    // Default adder slice width in bits.
    localparam int unsigned DEFAULT_SLICE = 8;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Index register width; keeps at least one bit when there is a single slice.
    function automatic int unsigned idx_width(input int unsigned nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

endpackage

// File: rtl/add_slice.sv
// Purely combinational SLICE-bit adder with carry-in and carry-out.
// Ports:
//   i_a, i_b   : W-bit addends
//   i_cin      : carry-in
//   o_sum_c    : W-bit sum (combinational)
//   o_cout_c   : carry-out (combinational)
module add_slice #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_sum_c,
    output logic         o_cout_c
);

    // One extra bit captures the carry out of the slice.
    logic [W:0] w_full;

    assign w_full   = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_cin};
    assign o_sum_c  = w_full[W-1:0];
    assign o_cout_c = w_full[W];

endmodule

// File: rtl/wide_add_seq.sv
// Sequential wide adder/subtractor: processes one SLICE-bit slice per cycle,
// LSB slice first, through a single shared add_slice instance.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid, in_ready  : request handshake (in_ready high only in IDLE)
//   a, b, cin, op       : operands, carry-in (add only), 0=add 1=subtract
//   out_valid, out_ready: result handshake (out_valid high only in DONE)
//   sum, cout, ovf      : result, carry-out (1 = no borrow on subtract),
//                         signed overflow
module wide_add_seq
    import wide_add_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = DEFAULT_SLICE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned IDX_W  = idx_width(NSLICE);

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic               r_cout;
    logic               r_ovf;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [IDX_W-1:0]   r_idx;

    logic [SLICE-1:0]   w_a_slice;
    logic [SLICE-1:0]   w_b_slice;
    logic [SLICE-1:0]   w_slice_sum;
    logic               w_slice_cout;
    logic               w_last;

    // Select the slice currently being processed.
    assign w_a_slice = r_a[32'(r_idx) * SLICE +: SLICE];
    assign w_b_slice = r_b[32'(r_idx) * SLICE +: SLICE];
    assign w_last    = (r_idx == IDX_W'(NSLICE - 1));

    add_slice #(
        .W        (SLICE)
    ) u_add_slice (
        .i_a      (w_a_slice),
        .i_b      (w_b_slice),
        .i_cin    (r_carry),
        .o_sum_c  (w_slice_sum),
        .o_cout_c (w_slice_cout)
    );

    // Sequencer and all result/handshake registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_carry     <= 1'b0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_idx       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        // Subtract is a + ~b + 1, so op is folded into B and the carry.
                        r_a        <= a;
                        r_b        <= op ? ~b : b;
                        r_carry    <= op ? 1'b1 : cin;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_CALC;
                    end
                end

                ST_CALC: begin
                    r_sum[32'(r_idx) * SLICE +: SLICE] <= w_slice_sum;
                    r_carry <= w_slice_cout;
                    r_idx   <= r_idx + IDX_W'(1);
                    if (w_last) begin
                        // Overflow uses the (possibly inverted) registered B.
                        r_cout      <= w_slice_cout;
                        r_ovf       <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                                       (w_slice_sum[SLICE-1] != r_a[WIDTH-1]);
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    // Request path stays closed on the exit cycle.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule
